// File: rtl/lock_pkg.sv
// Shared definitions for the digital lock: FSM state encoding and active-low
// 7-segment glyphs ({g,f,e,d,c,b,a}, 0 = segment lit).
package lock_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_CHECK   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_BCD0 = 7'b1000000;
  localparam logic [6:0] SEG_BCD1 = 7'b1111001;
  localparam logic [6:0] SEG_BCD2 = 7'b0100100;
  localparam logic [6:0] SEG_BCD3 = 7'b0110000;
  localparam logic [6:0] SEG_BCD4 = 7'b0011001;
  localparam logic [6:0] SEG_BCD5 = 7'b0010010;
  localparam logic [6:0] SEG_BCD6 = 7'b0000010;
  localparam logic [6:0] SEG_BCD7 = 7'b1111000;
  localparam logic [6:0] SEG_BCD8 = 7'b0000000;
  localparam logic [6:0] SEG_BCD9 = 7'b0010000;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show blank.
module bcd_to_seg
  import lock_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_BCD0;
      4'd1:    o_seg = SEG_BCD1;
      4'd2:    o_seg = SEG_BCD2;
      4'd3:    o_seg = SEG_BCD3;
      4'd4:    o_seg = SEG_BCD4;
      4'd5:    o_seg = SEG_BCD5;
      4'd6:    o_seg = SEG_BCD6;
      4'd7:    o_seg = SEG_BCD7;
      4'd8:    o_seg = SEG_BCD8;
      4'd9:    o_seg = SEG_BCD9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/lock_entry_fsm.sv
// Code-entry controller: edits a 4-digit BCD entry from button pulses, checks it
// against CODE, counts failed attempts and enforces a timed lockout.
module lock_entry_fsm
  import lock_pkg::*;
#(
  parameter logic [15:0] CODE           = 16'h1234,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned FAIL_CYCLES    = 50_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_next,
  input  logic       btn_enter,
  output logic [6:0] seg0,
  output logic [6:0] seg1,
  output logic [6:0] seg2,
  output logic [6:0] seg3,
  output logic [6:0] segStatus,
  output logic       unlocked,
  output state_t     dbg_state
);

  localparam int TW = $clog2(MAX_TRIES + 1);

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_digit [4];
  logic [3:0]      w_digit_nxt [4];
  logic [1:0]      r_cursor, w_cursor_nxt;
  logic [TW-1:0]   r_tries, w_tries_nxt, w_tries_inc;
  logic [31:0]     r_cnt, w_cnt_nxt;
  logic            w_match;
  logic [6:0]      w_seg [4];
  logic [6:0]      w_status;

  assign w_match     = ({r_digit[3], r_digit[2], r_digit[1], r_digit[0]} == CODE);
  assign w_tries_inc = r_tries + TW'(1);
  assign dbg_state   = r_state;

  // Next-state logic; every exit back to ENTRY starts a fresh entry at cursor 0.
  always_comb begin
    w_state_nxt  = r_state;
    w_digit_nxt  = r_digit;
    w_cursor_nxt = r_cursor;
    w_tries_nxt  = r_tries;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      ST_ENTRY: begin
        if (btn_enter) begin
          w_state_nxt = ST_CHECK;
        end else if (btn_next) begin
          w_cursor_nxt = r_cursor + 2'd1;
        end else if (btn_up) begin
          w_digit_nxt[r_cursor] = bcd_inc(r_digit[r_cursor]);
        end else if (btn_down) begin
          w_digit_nxt[r_cursor] = bcd_dec(r_digit[r_cursor]);
        end
      end
      ST_CHECK: begin
        w_cnt_nxt = 32'd0;
        if (w_match) begin
          w_state_nxt = ST_OPEN;
          w_tries_nxt = '0;
        end else begin
          w_tries_nxt = w_tries_inc;
          w_state_nxt = (w_tries_inc == TW'(MAX_TRIES)) ? ST_LOCKOUT : ST_FAIL;
        end
      end
      ST_OPEN: begin
        if (btn_enter) begin
          w_state_nxt  = ST_ENTRY;
          w_digit_nxt  = '{default: 4'd0};
          w_cursor_nxt = 2'd0;
        end
      end
      ST_FAIL: begin
        if (r_cnt == 32'(FAIL_CYCLES - 1)) begin
          w_state_nxt  = ST_ENTRY;
          w_digit_nxt  = '{default: 4'd0};
          w_cursor_nxt = 2'd0;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      ST_LOCKOUT: begin
        if (r_cnt == 32'(LOCKOUT_CYCLES - 1)) begin
          w_state_nxt  = ST_ENTRY;
          w_digit_nxt  = '{default: 4'd0};
          w_cursor_nxt = 2'd0;
          w_tries_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      default: w_state_nxt = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_ENTRY;
      r_digit  <= '{default: 4'd0};
      r_cursor <= 2'd0;
      r_tries  <= '0;
      r_cnt    <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_digit  <= w_digit_nxt;
      r_cursor <= w_cursor_nxt;
      r_tries  <= w_tries_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_dec
    bcd_to_seg u_dec (
      .i_bcd (r_digit[g]),
      .o_seg (w_seg[g])
    );
  end

  always_comb begin
    w_status = SEG_DASH;
    case (r_state)
      ST_OPEN:    w_status = SEG_O;
      ST_FAIL:    w_status = SEG_F;
      ST_LOCKOUT: w_status = SEG_L;
      default:    w_status = SEG_DASH;
    endcase
  end

  // Outputs lag the state registers by one edge so the display sees glitch-free values.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg0      <= SEG_BCD0;
      seg1      <= SEG_BCD0;
      seg2      <= SEG_BCD0;
      seg3      <= SEG_BCD0;
      segStatus <= SEG_DASH;
      unlocked  <= 1'b0;
    end else begin
      seg0      <= w_seg[0];
      seg1      <= w_seg[1];
      seg2      <= w_seg[2];
      seg3      <= w_seg[3];
      segStatus <= w_status;
      unlocked  <= (r_state == ST_OPEN);
    end
  end

endmodule

// File: tb/tb_lock_entry_fsm.sv
// Directed bench for lock_entry_fsm: a vector table for entry editing and open/relock,
// plus hand sequences for FAIL/LOCKOUT holds, dropped buttons and mid-lockout reset.
module tb_lock_entry_fsm;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G9 = 7'b0010000;
  localparam logic [6:0] GD = 7'b0111111;
  localparam logic [6:0] GO = 7'b1000000;
  localparam logic [6:0] GF = 7'b0001110;
  localparam logic [6:0] GL = 7'b1000111;

  // Button masks: {enter, next, up, down}
  localparam logic [3:0] B_NONE = 4'b0000;
  localparam logic [3:0] B_DN   = 4'b0001;
  localparam logic [3:0] B_UP   = 4'b0010;
  localparam logic [3:0] B_NXT  = 4'b0100;
  localparam logic [3:0] B_ENT  = 4'b1000;

  typedef struct {
    logic [3:0] btn;
    logic [6:0] s0, s1, s2, s3, st;
    logic       unl;
  } vec_t;

  logic clk, rst;
  logic btn_up, btn_down, btn_next, btn_enter;
  logic [6:0] seg0, seg1, seg2, seg3, segStatus;
  logic unlocked;
  lock_pkg::state_t dbg_state;

  int checks = 0;
  int failures = 0;
  vec_t tbl [28];

  lock_entry_fsm #(
    .CODE           (16'h1234),
    .MAX_TRIES      (3),
    .FAIL_CYCLES    (4),
    .LOCKOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_next  (btn_next),
    .btn_enter (btn_enter),
    .seg0      (seg0),
    .seg1      (seg1),
    .seg2      (seg2),
    .seg3      (seg3),
    .segStatus (segStatus),
    .unlocked  (unlocked),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] b, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3, input logic [6:0] st,
                              input logic unl);
    vec_t v;
    v.btn = b; v.s0 = s0; v.s1 = s1; v.s2 = s2; v.s3 = s3; v.st = st; v.unl = unl;
    return v;
  endfunction

  // Scoreboard
  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3, input logic [6:0] st,
                           input logic unl);
    chk({tag, ".seg0"}, seg0, s0);
    chk({tag, ".seg1"}, seg1, s1);
    chk({tag, ".seg2"}, seg2, s2);
    chk({tag, ".seg3"}, seg3, s3);
    chk({tag, ".status"}, segStatus, st);
    chk({tag, ".unlocked"}, {6'd0, unlocked}, {6'd0, unl});
  endtask

  // Drivers (all tasks start and end just after a falling edge)
  task automatic set_btn(input logic [3:0] b);
    {btn_enter, btn_next, btn_up, btn_down} = b;
  endtask

  task automatic pulse(input logic [3:0] b);
    set_btn(b);
    @(posedge clk); #1 set_btn(B_NONE);
    @(negedge clk);
  endtask

  // Pulse at edge N, then compare outputs after edge N+2 (button-to-display latency).
  task automatic apply_step(input string tag, input vec_t v);
    set_btn(v.btn);
    @(posedge clk); #1 set_btn(B_NONE);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_all(tag, v.s0, v.s1, v.s2, v.s3, v.st, v.unl);
  endtask

  task automatic enter_code_1234();
    repeat (4) pulse(B_UP);
    pulse(B_NXT);
    repeat (3) pulse(B_UP);
    pulse(B_NXT);
    repeat (2) pulse(B_UP);
    pulse(B_NXT);
    pulse(B_UP);
    pulse(B_NXT);
  endtask

  // Wrong-code submit followed by an n-cycle hold; buttons pressed during the hold must be dropped.
  task automatic hold_seq(input string tag, input logic [6:0] glyph, input int n,
                          input logic [6:0] s1_before, input logic with_up);
    logic [6:0] exp_st, exp_s1;
    set_btn(with_up ? (B_ENT | B_UP) : B_ENT);
    @(posedge clk); #1 set_btn(B_NONE);
    for (int k = 1; k <= n + 3; k++) begin
      if (k == 2) set_btn(B_NXT);
      else if (k == 3) set_btn(B_UP);
      else if (k == 4) set_btn(B_ENT);
      else if (k == 5) set_btn(B_DN);
      @(posedge clk); #1 set_btn(B_NONE);
      @(negedge clk);
      exp_st = (k >= 2 && k <= n + 1) ? glyph : GD;
      exp_s1 = (k <= n + 1) ? s1_before : G0;
      check_all($sformatf("%s_k%0d", tag, k), G0, exp_s1, G0, G0, exp_st, 1'b0);
    end
  endtask

  initial begin
    tbl[0]  = mk(B_DN,  G9, G0, G0, G0, GD, 1'b0);
    tbl[1]  = mk(B_UP,  G0, G0, G0, G0, GD, 1'b0);
    tbl[2]  = mk(B_NXT, G0, G0, G0, G0, GD, 1'b0);
    tbl[3]  = mk(B_NXT, G0, G0, G0, G0, GD, 1'b0);
    tbl[4]  = mk(B_NXT, G0, G0, G0, G0, GD, 1'b0);
    tbl[5]  = mk(B_NXT, G0, G0, G0, G0, GD, 1'b0);
    tbl[6]  = mk(B_UP,  G1, G0, G0, G0, GD, 1'b0);
    tbl[7]  = mk(B_DN,  G0, G0, G0, G0, GD, 1'b0);
    tbl[8]  = mk(B_UP,  G1, G0, G0, G0, GD, 1'b0);
    tbl[9]  = mk(B_UP,  G2, G0, G0, G0, GD, 1'b0);
    tbl[10] = mk(B_UP,  G3, G0, G0, G0, GD, 1'b0);
    tbl[11] = mk(B_UP,  G4, G0, G0, G0, GD, 1'b0);
    tbl[12] = mk(B_NXT, G4, G0, G0, G0, GD, 1'b0);
    tbl[13] = mk(B_UP,  G4, G1, G0, G0, GD, 1'b0);
    tbl[14] = mk(B_UP,  G4, G2, G0, G0, GD, 1'b0);
    tbl[15] = mk(B_UP,  G4, G3, G0, G0, GD, 1'b0);
    tbl[16] = mk(B_NXT, G4, G3, G0, G0, GD, 1'b0);
    tbl[17] = mk(B_UP,  G4, G3, G1, G0, GD, 1'b0);
    tbl[18] = mk(B_UP,  G4, G3, G2, G0, GD, 1'b0);
    tbl[19] = mk(B_NXT, G4, G3, G2, G0, GD, 1'b0);
    tbl[20] = mk(B_UP,  G4, G3, G2, G1, GD, 1'b0);
    tbl[21] = mk(B_NXT, G4, G3, G2, G1, GD, 1'b0);
    tbl[22] = mk(B_ENT, G4, G3, G2, G1, GO, 1'b1);
    tbl[23] = mk(B_UP,  G4, G3, G2, G1, GO, 1'b1);
    tbl[24] = mk(B_NXT, G4, G3, G2, G1, GO, 1'b1);
    tbl[25] = mk(B_ENT, G0, G0, G0, G0, GD, 1'b0);
    tbl[26] = mk(B_NXT | B_UP, G0, G0, G0, G0, GD, 1'b0);
    tbl[27] = mk(B_UP,  G0, G1, G0, G0, GD, 1'b0);

    rst = 1'b1;
    set_btn(B_NONE);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset", G0, G0, G0, G0, GD, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 28; i++) apply_step($sformatf("vec%0d", i), tbl[i]);

    // enter+up together: CHECK wins, digit1 stays 1 until the FAIL exit clears it (tries=1)
    hold_seq("fail_a", GF, 4, G1, 1'b1);
    apply_step("cursor0_up", mk(B_UP, G1, G0, G0, G0, GD, 1'b0));
    apply_step("cursor0_dn", mk(B_DN, G0, G0, G0, G0, GD, 1'b0));
    hold_seq("fail_b", GF, 4, G0, 1'b0);
    hold_seq("lockout", GL, 8, G0, 1'b0);

    enter_code_1234();
    apply_step("open_after_lock", mk(B_ENT, G4, G3, G2, G1, GO, 1'b1));
    apply_step("relock", mk(B_ENT, G0, G0, G0, G0, GD, 1'b0));

    // Reach LOCKOUT again and reset part-way through the countdown.
    hold_seq("fail_c", GF, 4, G0, 1'b0);
    hold_seq("fail_d", GF, 4, G0, 1'b0);
    pulse(B_ENT);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_lockout.status", segStatus, GL);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_all("reset_mid_lockout", G0, G0, G0, G0, GD, 1'b0);
    enter_code_1234();
    apply_step("open_after_reset", mk(B_ENT, G4, G3, G2, G1, GO, 1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
